// File: rtl/window_buffer.sv
// Sliding-window stage: gathers decimated samples into a KERNEL_SIZE-deep window for the first conv layer.
// Define WINDOW_FLUSH_EN to add the synchronous window_flush input.
module window_buffer #(
  parameter int DATA_WIDTH  = 12,
  parameter int KERNEL_SIZE = 8,
  parameter int STRIDE      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef WINDOW_FLUSH_EN
  input  logic                              window_flush,
`endif
  output logic                              window_ready_in,
  input  logic                              window_valid_in,
  input  logic [DATA_WIDTH-1:0]             window_data_in,
  input  logic                              window_ready_out,
  output logic                              window_valid_out,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] window_data_out
);

  localparam int FW = $clog2(KERNEL_SIZE + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FW-1:0] FILL_FULL   = FW'(KERNEL_SIZE);
  localparam logic [FW-1:0] FILL_LAST   = FW'(KERNEL_SIZE - 1);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

  logic [KERNEL_SIZE*DATA_WIDTH-1:0] shift_q;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] shift_next;
  logic [FW-1:0]                     fill_q;
  logic [SW-1:0]                     stride_q;
  logic                              accept;
  logic                              emit;
  logic                              flush;

`ifdef WINDOW_FLUSH_EN
  assign flush = window_flush;
`else
  assign flush = 1'b0;
`endif

  assign window_ready_in = !window_valid_out || window_ready_out;
  assign accept          = window_valid_in && window_ready_in;
  assign shift_next      = {window_data_in, shift_q[KERNEL_SIZE*DATA_WIDTH-1:DATA_WIDTH]};

  // The completing fill emits once; afterwards every STRIDE-th accept emits.
  assign emit = accept && ((fill_q == FILL_LAST) ||
                           ((fill_q == FILL_FULL) && (stride_q == STRIDE_LAST)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q          <= '0;
      fill_q           <= '0;
      stride_q         <= '0;
      window_valid_out <= 1'b0;
      window_data_out  <= '0;
    end else if (flush) begin
      shift_q          <= '0;
      fill_q           <= '0;
      stride_q         <= '0;
      window_valid_out <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= shift_next;
        if (fill_q != FILL_FULL) begin
          fill_q   <= fill_q + FW'(1);
          stride_q <= '0;
        end else if (stride_q == STRIDE_LAST) begin
          stride_q <= '0;
        end else begin
          stride_q <= stride_q + SW'(1);
        end
      end
      // A new emission on the same edge as a consume keeps valid high with fresh data.
      if (emit) begin
        window_data_out  <= shift_next;
        window_valid_out <= 1'b1;
      end else if (window_valid_out && window_ready_out) begin
        window_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer: three instances (K4/S2, K4/S1, K3/S5) with hand-computed windows.
module tb_window_buffer;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_vin = 1'b0, a_rdy = 1'b0, a_rin, a_vout;
  logic [DW-1:0] a_din = '0;
  logic [4*DW-1:0] a_dout;
  logic          b_vin = 1'b0, b_rdy = 1'b0, b_rin, b_vout;
  logic [DW-1:0] b_din = '0;
  logic [4*DW-1:0] b_dout;
  logic          c_vin = 1'b0, c_rdy = 1'b0, c_rin, c_vout;
  logic [DW-1:0] c_din = '0;
  logic [3*DW-1:0] c_dout;
`ifdef WINDOW_FLUSH_EN
  logic a_flush = 1'b0, b_flush = 1'b0, c_flush = 1'b0;
`endif

  window_buffer #(.DATA_WIDTH(DW), .KERNEL_SIZE(4), .STRIDE(2)) dut_a (
    .clk(clk), .rst(rst_n),
`ifdef WINDOW_FLUSH_EN
    .window_flush(a_flush),
`endif
    .window_ready_in(a_rin), .window_valid_in(a_vin), .window_data_in(a_din),
    .window_ready_out(a_rdy), .window_valid_out(a_vout), .window_data_out(a_dout)
  );

  window_buffer #(.DATA_WIDTH(DW), .KERNEL_SIZE(4), .STRIDE(1)) dut_b (
    .clk(clk), .rst(rst_n),
`ifdef WINDOW_FLUSH_EN
    .window_flush(b_flush),
`endif
    .window_ready_in(b_rin), .window_valid_in(b_vin), .window_data_in(b_din),
    .window_ready_out(b_rdy), .window_valid_out(b_vout), .window_data_out(b_dout)
  );

  window_buffer #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .STRIDE(5)) dut_c (
    .clk(clk), .rst(rst_n),
`ifdef WINDOW_FLUSH_EN
    .window_flush(c_flush),
`endif
    .window_ready_in(c_rin), .window_valid_in(c_vin), .window_data_in(c_din),
    .window_ready_out(c_rdy), .window_valid_out(c_vout), .window_data_out(c_dout)
  );

  typedef struct {
    int          cyc;
    logic [47:0] data;
  } win_t;

  win_t qa[$];
  win_t qb[$];
  win_t qc[$];

  // Inputs change just after posedge, so the negedge view equals the next edge's handshake.
  always @(negedge clk) begin
    if (a_vout && a_rdy) qa.push_back('{cyc, 48'(a_dout)});
    if (b_vout && b_rdy) qb.push_back('{cyc, 48'(b_dout)});
    if (c_vout && c_rdy) qc.push_back('{cyc, 48'(c_dout)});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] w4(input int a, input int b, input int c, input int d);
    return {12'(d), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic [47:0] w3(input int a, input int b, input int c);
    return {12'd0, 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic getRin(input int inst);
    case (inst)
      0:       return a_rin;
      1:       return b_rin;
      default: return c_rin;
    endcase
  endfunction

  function automatic int qSize(input int inst);
    case (inst)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [47:0] winData(input int inst, input int i);
    if (i >= qSize(inst)) return 48'hFFFF_FFFF_FFFF;
    case (inst)
      0:       return qa[i].data;
      1:       return qb[i].data;
      default: return qc[i].data;
    endcase
  endfunction

  function automatic int winCyc(input int inst, input int i);
    if (i >= qSize(inst)) return -100;
    case (inst)
      0:       return qa[i].cyc;
      1:       return qb[i].cyc;
      default: return qc[i].cyc;
    endcase
  endfunction

  task automatic setIn(input int inst, input logic v, input int d);
    case (inst)
      0:       begin a_vin = v; a_din = DW'(d); end
      1:       begin b_vin = v; b_din = DW'(d); end
      default: begin c_vin = v; c_din = DW'(d); end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until accepted; returns the accept cycle and stall count.
  task automatic applyStimulus(input int inst, input int d, output int accCyc, output int waits);
    accCyc = -1;
    waits  = 0;
    setIn(inst, 1'b1, d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (getRin(inst)) begin
        accCyc = cyc;
        break;
      end
      waits++;
    end
    if (accCyc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    setIn(inst, 1'b0, 0);
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int acc;
    int acc4;
    int w;
    int waitSum;

    $display("[TB] start");
    idle(3);
    checkOutput("rst_a_vout", 64'(a_vout), 64'd0);
    checkOutput("rst_a_dout", 64'(a_dout), 64'd0);
    checkOutput("rst_a_rin",  64'(a_rin),  64'd1);
    checkOutput("rst_b_vout", 64'(b_vout), 64'd0);
    checkOutput("rst_b_dout", 64'(b_dout), 64'd0);
    checkOutput("rst_c_vout", 64'(c_vout), 64'd0);
    checkOutput("rst_c_dout", 64'(c_dout), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // K4 S2, samples 1..10 back-to-back
    a_rdy = 1'b1;
    acc4  = -1;
    for (int v = 1; v <= 10; v++) begin
      applyStimulus(0, v, acc, w);
      if (v == 4) acc4 = acc;
    end
    idle(3);
    checkOutput("s2_count", 64'(qSize(0)), 64'd4);
    checkOutput("s2_win0", 64'(winData(0, 0)), 64'(w4(1, 2, 3, 4)));
    checkOutput("s2_win1", 64'(winData(0, 1)), 64'(w4(3, 4, 5, 6)));
    checkOutput("s2_win2", 64'(winData(0, 2)), 64'(w4(5, 6, 7, 8)));
    checkOutput("s2_win3", 64'(winData(0, 3)), 64'(w4(7, 8, 9, 10)));
    checkOutput("s2_latency", 64'(winCyc(0, 0)), 64'(acc4 + 1));

    // K4 S1, samples 1..6, full throughput
    b_rdy   = 1'b1;
    waitSum = 0;
    acc4    = -1;
    for (int v = 1; v <= 6; v++) begin
      applyStimulus(1, v, acc, w);
      waitSum += w;
      if (v == 4) acc4 = acc;
    end
    idle(3);
    checkOutput("s1_count", 64'(qSize(1)), 64'd3);
    checkOutput("s1_win0", 64'(winData(1, 0)), 64'(w4(1, 2, 3, 4)));
    checkOutput("s1_win1", 64'(winData(1, 1)), 64'(w4(2, 3, 4, 5)));
    checkOutput("s1_win2", 64'(winData(1, 2)), 64'(w4(3, 4, 5, 6)));
    checkOutput("s1_cyc0", 64'(winCyc(1, 0)), 64'(acc4 + 1));
    checkOutput("s1_cyc1", 64'(winCyc(1, 1)), 64'(acc4 + 2));
    checkOutput("s1_cyc2", 64'(winCyc(1, 2)), 64'(acc4 + 3));
    checkOutput("s1_no_stall", 64'(waitSum), 64'd0);

    // K4 S1 back-pressure for 5 cycles after the first window
    resetPulse();
    qb.delete();
    b_rdy = 1'b0;
    for (int v = 1; v <= 4; v++) applyStimulus(1, v, acc, w);
    setIn(1, 1'b1, 5);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_rin",  64'(b_rin),  64'd0);
      checkOutput("bp_vout", 64'(b_vout), 64'd1);
      checkOutput("bp_dout", 64'(b_dout), 64'(w4(1, 2, 3, 4)));
    end
    @(posedge clk);
    #1;
    b_rdy = 1'b1;
    applyStimulus(1, 5, acc, w);
    applyStimulus(1, 6, acc, w);
    idle(3);
    checkOutput("bp_count", 64'(qSize(1)), 64'd3);
    checkOutput("bp_win0", 64'(winData(1, 0)), 64'(w4(1, 2, 3, 4)));
    checkOutput("bp_win1", 64'(winData(1, 1)), 64'(w4(2, 3, 4, 5)));
    checkOutput("bp_win2", 64'(winData(1, 2)), 64'(w4(3, 4, 5, 6)));

    // Reset in the middle of a partial fill
    resetPulse();
    applyStimulus(1, 1, acc, w);
    applyStimulus(1, 2, acc, w);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vout", 64'(b_vout), 64'd0);
    checkOutput("mid_rst_dout", 64'(b_dout), 64'd0);
    checkOutput("mid_rst_rin",  64'(b_rin),  64'd1);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    qb.delete();
    applyStimulus(1, 10, acc, w);
    applyStimulus(1, 20, acc, w);
    applyStimulus(1, 30, acc, w);
    applyStimulus(1, 40, acc, w);
    idle(3);
    checkOutput("mid_rst_count", 64'(qSize(1)), 64'd1);
    checkOutput("mid_rst_win", 64'(winData(1, 0)), 64'(w4(10, 20, 30, 40)));

    // K3 S5, samples 1..13 with skipped samples between windows
    c_rdy = 1'b1;
    for (int v = 1; v <= 13; v++) applyStimulus(2, v, acc, w);
    idle(3);
    checkOutput("s5_count", 64'(qSize(2)), 64'd3);
    checkOutput("s5_win0", 64'(winData(2, 0)), 64'(w3(1, 2, 3)));
    checkOutput("s5_win1", 64'(winData(2, 1)), 64'(w3(6, 7, 8)));
    checkOutput("s5_win2", 64'(winData(2, 2)), 64'(w3(11, 12, 13)));

`ifdef WINDOW_FLUSH_EN
    // Flush after a partial fill also drops the sample offered alongside it
    resetPulse();
    qb.delete();
    b_rdy = 1'b1;
    for (int v = 1; v <= 3; v++) applyStimulus(1, v, acc, w);
    b_flush = 1'b1;
    setIn(1, 1'b1, 99);
    @(posedge clk);
    #1;
    b_flush = 1'b0;
    setIn(1, 1'b0, 0);
    checkOutput("flush_vout", 64'(b_vout), 64'd0);
    for (int v = 5; v <= 8; v++) applyStimulus(1, v, acc, w);
    idle(3);
    checkOutput("flush_count", 64'(qSize(1)), 64'd1);
    checkOutput("flush_win", 64'(winData(1, 0)), 64'(w4(5, 6, 7, 8)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
